// File: rtl/mac_array_nxm_if.sv
// Bundle of weight-load, activation-stream and result signals for mac_array_nxm.
// The master modport drives weights and vectors; the slave modport is the array.
interface mac_array_nxm_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int DW    = 8,
  parameter int OUT_W = 16
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                    W_LOAD;
  logic [RW-1:0]           WROW;
  logic [COLS*DW-1:0]      WDATA;
  logic                    W_SWAP;
  logic                    IVALID;
  logic                    IREADY;
  logic [COLS*DW-1:0]      IDATA;
  logic                    SAT_EN;
  logic                    OVALID;
  logic [ROWS*OUT_W-1:0]   ODATA;
  logic                    BUSY;

  modport master (
    output W_LOAD, WROW, WDATA, W_SWAP, IVALID, IDATA, SAT_EN,
    input  IREADY, OVALID, ODATA, BUSY
  );

  modport slave (
    input  W_LOAD, WROW, WDATA, W_SWAP, IVALID, IDATA, SAT_EN,
    output IREADY, OVALID, ODATA, BUSY
  );
endinterface

// File: rtl/mac_array_nxm.sv
// Weight-stationary ROWSxCOLS systolic MAC array computing y = W*a per vector, with
// internal skew/deskew, double-buffered weights, in-flight tracking and wrap/saturate output.
module mac_array_nxm #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int DW    = 8,
  parameter int OUT_W = 16
) (
  input logic             CLK,
  input logic             RSTN,
  mac_array_nxm_if.slave  bus
);

  localparam int ACC_W = 2 * DW + $clog2(COLS);
  localparam int L     = ROWS + COLS + 1;
  localparam int CNT_W = $clog2(L + 2);
  localparam int CV_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;

  localparam logic signed [CV_W-1:0] OMAX = {{(CV_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CV_W-1:0] OMIN = {{(CV_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {ST_IDLE, ST_PENDING} swap_state_e;

  swap_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   accept;
  logic                   commit;
  logic                   row_ok;
  logic                   busy;

  logic signed [DW-1:0]   wsh_q  [ROWS][COLS];
  logic signed [DW-1:0]   wact_q [ROWS][COLS];
  logic signed [DW-1:0]   in_q   [COLS];
  logic [L-1:0]           vld_q;
  logic [L-1:0]           sat_q;
  logic                   ovalid_q;
  logic [ROWS*OUT_W-1:0]  odata_q;

  logic signed [DW-1:0]    act_w   [ROWS][COLS];
  logic signed [ACC_W-1:0] psum_w  [ROWS][COLS];
  logic signed [ACC_W-1:0] row_out [ROWS];

  assign busy       = (cnt_q != '0);
  assign bus.IREADY = (state_q == ST_IDLE);
  assign bus.BUSY   = busy;
  assign bus.OVALID = ovalid_q;
  assign bus.ODATA  = odata_q;
  assign accept     = bus.IVALID && (state_q == ST_IDLE);
  assign row_ok     = (int'(bus.WROW) < ROWS);

  // Swap handshake: a commit may only happen when no vector is in flight or entering.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.W_SWAP) begin
          if (busy || accept) state_d = ST_PENDING;
          else                commit  = 1'b1;
        end
      end
      ST_PENDING: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept, ovalid_q})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    // NOTE: both banks must read as zero straight out of reset, so they are flops with
    // an explicit reset rather than a RAM.
    if (!RSTN) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          wsh_q[r][c]  <= '0;
          wact_q[r][c] <= '0;
        end
      end
    end else begin
      // NOTE: non-blocking assignment makes a commit copy the shadow bank as it was
      // before this edge, even when a W_LOAD writes the shadow on the same edge.
      if (commit) wact_q <= wsh_q;
      if (bus.W_LOAD && row_ok) begin
        for (int c = 0; c < COLS; c++) wsh_q[bus.WROW][c] <= bus.WDATA[(COLS-c)*DW-1 -: DW];
      end
    end
  end

  // Empty slots enter as zero activations; the token and mode bit ride a side chain.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int c = 0; c < COLS; c++) in_q[c] <= '0;
      vld_q <= '0;
      sat_q <= '0;
    end else begin
      for (int c = 0; c < COLS; c++) in_q[c] <= accept ? bus.IDATA[(COLS-c)*DW-1 -: DW] : '0;
      vld_q <= {vld_q[L-2:0], accept};
      sat_q <= {sat_q[L-2:0], accept & bus.SAT_EN};
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_skew
    if (c == 0) begin : g_direct
      assign act_w[0][c] = in_q[c];
    end else begin : g_dly
      logic signed [DW-1:0] sk_q [c];
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          for (int k = 0; k < c; k++) sk_q[k] <= '0;
        end else begin
          sk_q[0] <= in_q[c];
          for (int k = 1; k < c; k++) sk_q[k] <= sk_q[k-1];
        end
      end
      assign act_w[0][c] = sk_q[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      logic signed [ACC_W-1:0] psum_q;
      logic signed [ACC_W-1:0] psum_in;
      logic signed [2*DW-1:0]  prod;

      if (c == 0) begin : g_first
        assign psum_in = '0;
      end else begin : g_chain
        assign psum_in = psum_w[r][c-1];
      end

      assign prod = (2*DW)'(act_w[r][c]) * (2*DW)'(wact_q[r][c]);

      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) psum_q <= '0;
        else       psum_q <= psum_in + ACC_W'(prod);
      end
      assign psum_w[r][c] = psum_q;

      // The bottom row has nobody below it to pass activations to.
      if (r < ROWS - 1) begin : g_act
        logic signed [DW-1:0] act_q;
        always_ff @(posedge CLK or negedge RSTN) begin
          if (!RSTN) act_q <= '0;
          else       act_q <= act_w[r][c];
        end
        assign act_w[r+1][c] = act_q;
      end
    end

    // Row r finishes r cycles after row 0; delay so all rows line up one stage before ODATA.
    logic signed [ACC_W-1:0] dk_q [ROWS-r];
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        for (int k = 0; k < ROWS - r; k++) dk_q[k] <= '0;
      end else begin
        dk_q[0] <= psum_w[r][COLS-1];
        for (int k = 1; k < ROWS - r; k++) dk_q[k] <= dk_q[k-1];
      end
    end
    assign row_out[r] = dk_q[ROWS-r-1];
  end

  function automatic logic [OUT_W-1:0] convert(input logic signed [ACC_W-1:0] s,
                                               input logic sat);
    logic signed [CV_W-1:0] x;
    x = CV_W'(s);
    if (sat && (x > OMAX)) return OMAX[OUT_W-1:0];
    if (sat && (x < OMIN)) return OMIN[OUT_W-1:0];
    return x[OUT_W-1:0];
  endfunction

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ovalid_q <= 1'b0;
      odata_q  <= '0;
    end else begin
      ovalid_q <= vld_q[L-1];
      if (vld_q[L-1]) begin
        for (int r = 0; r < ROWS; r++) begin
          odata_q[(ROWS-r)*OUT_W-1 -: OUT_W] <= convert(row_out[r], sat_q[L-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_array_nxm.sv
// Directed bench for mac_array_nxm: default 4x4 instance plus a 3x2 instance for
// out-of-range row addressing and a non-default latency.
module tb_mac_array_nxm;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  mac_array_nxm_if #(.ROWS(4), .COLS(4), .DW(8), .OUT_W(16)) bus ();
  mac_array_nxm #(.ROWS(4), .COLS(4), .DW(8), .OUT_W(16)) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bus)
  );

  mac_array_nxm_if #(.ROWS(3), .COLS(2), .DW(8), .OUT_W(16)) bus3 ();
  mac_array_nxm #(.ROWS(3), .COLS(2), .DW(8), .OUT_W(16)) dut3 (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bus3)
  );

  function automatic logic [31:0] vec4(input int a0, input int a1, input int a2, input int a3);
    return {8'(a0), 8'(a1), 8'(a2), 8'(a3)};
  endfunction

  function automatic logic [63:0] res4(input int y0, input int y1, input int y2, input int y3);
    return {16'(y0), 16'(y1), 16'(y2), 16'(y3)};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.W_LOAD = 1'b0;  bus.WROW = '0;  bus.WDATA = '0;  bus.W_SWAP = 1'b0;
    bus.IVALID = 1'b0;  bus.IDATA = '0; bus.SAT_EN = 1'b0;
    bus3.W_LOAD = 1'b0; bus3.WROW = '0; bus3.WDATA = '0; bus3.W_SWAP = 1'b0;
    bus3.IVALID = 1'b0; bus3.IDATA = '0; bus3.SAT_EN = 1'b0;
  endtask

  task automatic load_row(input int r, input logic [31:0] d);
    bus.W_LOAD = 1'b1;
    bus.WROW   = 2'(r);
    bus.WDATA  = d;
    tick();
    bus.W_LOAD = 1'b0;
  endtask

  task automatic load_diag(input int s);
    logic [31:0] d;
    for (int r = 0; r < 4; r++) begin
      d = '0;
      d[(4-r)*8-1 -: 8] = 8'(s);
      load_row(r, d);
    end
  endtask

  task automatic load_all(input int v);
    for (int r = 0; r < 4; r++) load_row(r, vec4(v, v, v, v));
  endtask

  task automatic swap_idle();
    bus.W_SWAP = 1'b1;
    tick();
    bus.W_SWAP = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic sat);
    bus.IVALID = 1'b1;
    bus.IDATA  = d;
    bus.SAT_EN = sat;
    tick();
    bus.IVALID = 1'b0;
    bus.SAT_EN = 1'b0;
  endtask

  task automatic wait_ovalid(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.OVALID) begin
        ok = 1'b1;
        break;
      end
      tick();
      cyc++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && bus.BUSY; i++) tick();
    n_vec++;
    if (bus.BUSY !== 1'b0) begin
      n_err++; $display("FAIL drain_timeout: BUSY=%b want 0", bus.BUSY);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_vec++; if (bus.OVALID !== 1'b0) begin n_err++; $display("FAIL reset_ovalid: got %b want 0", bus.OVALID); end
    n_vec++; if (bus.ODATA !== 64'h0) begin n_err++; $display("FAIL reset_odata: got %h want 0", bus.ODATA); end
    n_vec++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
    n_vec++; if (bus.IREADY !== 1'b1) begin n_err++; $display("FAIL reset_iready: got %b want 1", bus.IREADY); end
    @(negedge CLK);
    RSTN = 1'b1;
    tick();
  endtask

  task automatic test_identity();
    bit early;
    load_diag(1);
    swap_idle();
    send(vec4(1, 2, 3, 4), 1'b1);
    early = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (bus.OVALID) early = 1'b1;
    end
    n_vec++; if (early !== 1'b0) begin n_err++; $display("FAIL ident_early_ovalid: got 1 want 0 before edge k+9"); end
    tick();
    n_vec++; if (bus.OVALID !== 1'b1) begin n_err++; $display("FAIL ident_ovalid_k9: got %b want 1", bus.OVALID); end
    n_vec++; if (bus.ODATA !== res4(1, 2, 3, 4)) begin n_err++; $display("FAIL ident_odata: got %h want %h", bus.ODATA, res4(1, 2, 3, 4)); end
    n_vec++; if (bus.BUSY !== 1'b1) begin n_err++; $display("FAIL ident_busy_during_ovalid: got %b want 1", bus.BUSY); end
    tick();
    n_vec++; if (bus.OVALID !== 1'b0) begin n_err++; $display("FAIL ident_ovalid_k10: got %b want 0", bus.OVALID); end
    n_vec++; if (bus.ODATA !== res4(1, 2, 3, 4)) begin n_err++; $display("FAIL ident_odata_hold: got %h want %h", bus.ODATA, res4(1, 2, 3, 4)); end
    n_vec++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL ident_busy_after: got %b want 0", bus.BUSY); end
  endtask

  task automatic test_saturation();
    int cyc;
    bit ok;
    drain();
    load_all(127);
    swap_idle();
    bus.IVALID = 1'b1; bus.IDATA = vec4(127, 127, 127, 127);
    bus.SAT_EN = 1'b1; tick();
    bus.SAT_EN = 1'b0; tick();
    bus.IVALID = 1'b0;
    wait_ovalid(cyc, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL sat_pos_timeout: no OVALID within 40 cycles"); end
    n_vec++; if (bus.ODATA !== {4{16'h7FFF}}) begin n_err++; $display("FAIL sat_pos_clamp: got %h want %h", bus.ODATA, {4{16'h7FFF}}); end
    tick();
    n_vec++; if (bus.OVALID !== 1'b1 || bus.ODATA !== {4{16'hFC04}}) begin
      n_err++; $display("FAIL sat_pos_wrap: ovalid=%b got %h want %h", bus.OVALID, bus.ODATA, {4{16'hFC04}});
    end
    drain();
    load_all(-128);
    swap_idle();
    bus.IVALID = 1'b1; bus.IDATA = vec4(127, 127, 127, 127);
    bus.SAT_EN = 1'b1; tick();
    bus.SAT_EN = 1'b0; tick();
    bus.IVALID = 1'b0;
    wait_ovalid(cyc, ok);
    n_vec++; if (!ok || bus.ODATA !== {4{16'h8000}}) begin
      n_err++; $display("FAIL sat_neg_clamp: ok=%b got %h want %h", ok, bus.ODATA, {4{16'h8000}});
    end
    tick();
    n_vec++; if (bus.OVALID !== 1'b1 || bus.ODATA !== {4{16'h0200}}) begin
      n_err++; $display("FAIL sat_neg_wrap: ovalid=%b got %h want %h", bus.OVALID, bus.ODATA, {4{16'h0200}});
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ok;
    bit stalled;
    drain();
    load_all(1);
    swap_idle();
    stalled = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      bus.IVALID = 1'b1;
      bus.IDATA  = vec4(n, n, n, n);
      if (!bus.IREADY) stalled = 1'b1;
      tick();
    end
    bus.IVALID = 1'b0;
    n_vec++; if (stalled !== 1'b0) begin n_err++; $display("FAIL b2b_iready: got stall want none"); end
    wait_ovalid(cyc, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_timeout: no OVALID within 40 cycles"); end
    for (int n = 1; n <= 8; n++) begin
      n_vec++; if (bus.OVALID !== 1'b1 || bus.ODATA !== res4(4*n, 4*n, 4*n, 4*n)) begin
        n_err++; $display("FAIL b2b_result_%0d: ovalid=%b got %h want %h", n, bus.OVALID, bus.ODATA, res4(4*n, 4*n, 4*n, 4*n));
      end
      if (n == 8) begin
        n_vec++; if (bus.BUSY !== 1'b1) begin n_err++; $display("FAIL b2b_busy_last: got %b want 1", bus.BUSY); end
      end
      tick();
    end
    n_vec++; if (bus.OVALID !== 1'b0 || bus.BUSY !== 1'b0) begin
      n_err++; $display("FAIL b2b_after: ovalid=%b busy=%b want 0 0", bus.OVALID, bus.BUSY);
    end
  endtask

  task automatic test_swap_busy();
    int  cyc;
    bit  ok;
    int  ov_i;
    int  rd_i;
    drain();
    load_diag(1);
    swap_idle();
    send(vec4(1, 2, 3, 4), 1'b0);
    load_diag(2);
    swap_idle();
    n_vec++; if (bus.IREADY !== 1'b0 || bus.BUSY !== 1'b1) begin
      n_err++; $display("FAIL swap_pending: iready=%b busy=%b want 0 1", bus.IREADY, bus.BUSY);
    end
    bus.IVALID = 1'b1;
    bus.IDATA  = vec4(1, 2, 3, 4);
    ov_i = -1;
    rd_i = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.IREADY) begin
        rd_i = i;
        break;
      end
      if (bus.OVALID) begin
        ov_i = i;
        n_vec++; if (bus.ODATA !== res4(1, 2, 3, 4)) begin
          n_err++; $display("FAIL swap_old_bank: got %h want %h", bus.ODATA, res4(1, 2, 3, 4));
        end
      end
      tick();
    end
    n_vec++; if (ov_i < 0 || rd_i - ov_i != 2) begin
      n_err++; $display("FAIL swap_iready_release: ovalid at %0d iready at %0d want gap 2", ov_i, rd_i);
    end
    tick();
    bus.IVALID = 1'b0;
    wait_ovalid(cyc, ok);
    n_vec++; if (!ok || cyc != 9) begin n_err++; $display("FAIL swap_new_latency: ok=%b got %0d want 9", ok, cyc); end
    n_vec++; if (bus.ODATA !== res4(2, 4, 6, 8)) begin
      n_err++; $display("FAIL swap_new_bank: got %h want %h", bus.ODATA, res4(2, 4, 6, 8));
    end
    tick();
    n_vec++; if (bus.OVALID !== 1'b0) begin n_err++; $display("FAIL swap_single_result: got %b want 0", bus.OVALID); end
  endtask

  task automatic test_collision();
    int cyc;
    bit ok;
    drain();
    load_diag(3);
    bus.W_SWAP = 1'b1;
    bus.W_LOAD = 1'b1;
    bus.WROW   = 2'd0;
    bus.WDATA  = vec4(5, 0, 0, 0);
    tick();
    bus.W_SWAP = 1'b0;
    bus.W_LOAD = 1'b0;
    send(vec4(1, 2, 3, 4), 1'b0);
    wait_ovalid(cyc, ok);
    n_vec++; if (!ok || bus.ODATA !== res4(3, 6, 9, 12)) begin
      n_err++; $display("FAIL collide_commit: ok=%b got %h want %h", ok, bus.ODATA, res4(3, 6, 9, 12));
    end
    drain();
    swap_idle();
    send(vec4(1, 2, 3, 4), 1'b0);
    wait_ovalid(cyc, ok);
    n_vec++; if (!ok || bus.ODATA !== res4(5, 6, 9, 12)) begin
      n_err++; $display("FAIL collide_second_swap: ok=%b got %h want %h", ok, bus.ODATA, res4(5, 6, 9, 12));
    end
  endtask

  task automatic test_wrow_range();
    int cyc;
    cyc = -1;
    for (int r = 0; r < 3; r++) begin
      bus3.W_LOAD = 1'b1;
      bus3.WROW   = 2'(r);
      bus3.WDATA  = {8'(r + 1), 8'(r + 1)};
      tick();
    end
    bus3.WROW  = 2'd3;
    bus3.WDATA = {8'd9, 8'd9};
    tick();
    bus3.W_LOAD = 1'b0;
    bus3.W_SWAP = 1'b1;
    tick();
    bus3.W_SWAP = 1'b0;
    bus3.IVALID = 1'b1;
    bus3.IDATA  = {8'd1, 8'd2};
    tick();
    bus3.IVALID = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus3.OVALID) begin
        cyc = i;
        break;
      end
      tick();
    end
    n_vec++; if (cyc != 6) begin n_err++; $display("FAIL small_latency: got %0d want 6", cyc); end
    n_vec++; if (bus3.ODATA !== {16'd3, 16'd6, 16'd9}) begin
      n_err++; $display("FAIL wrow_out_of_range: got %h want %h", bus3.ODATA, {16'd3, 16'd6, 16'd9});
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    bit leaked;
    drain();
    load_diag(1);
    swap_idle();
    send(vec4(1, 2, 3, 4), 1'b0);
    repeat (3) tick();
    n_vec++; if (bus.BUSY !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy_before: got %b want 1", bus.BUSY); end
    #1;
    RSTN = 1'b0;
    #1;
    n_vec++; if (bus.ODATA !== 64'h0 || bus.OVALID !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_outputs: ovalid=%b odata=%h want 0 0", bus.OVALID, bus.ODATA);
    end
    n_vec++; if (bus.BUSY !== 1'b0 || bus.IREADY !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_flags: busy=%b iready=%b want 0 1", bus.BUSY, bus.IREADY);
    end
    @(negedge CLK);
    RSTN = 1'b1;
    leaked = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.OVALID) leaked = 1'b1;
    end
    n_vec++; if (leaked !== 1'b0) begin n_err++; $display("FAIL rst_mid_leak: got OVALID want none"); end
    swap_idle();
    send(vec4(1, 2, 3, 4), 1'b0);
    wait_ovalid(cyc, ok);
    n_vec++; if (!ok || bus.ODATA !== 64'h0) begin
      n_err++; $display("FAIL rst_banks_cleared: ok=%b got %h want 0", ok, bus.ODATA);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_saturation();
    test_back_to_back();
    test_swap_busy();
    test_collision();
    test_wrow_range();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
